// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path and its FIFO.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Two-of-three vote used to resolve each serial bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Read/write pointer width for a power-of-two FIFO.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width; one extra bit so "full" is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted
// only when a pop happens in the same cycle (the pop frees the slot).
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic                          empty,
  output logic                          full,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Next storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // FIFO state registers; storage cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, false-start rejection,
// sticky error flags and a receive FIFO drained by rd_en.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | resolving the start bit; a 1 is a false start
// DATA   | shifting DATA_BITS bits in, LSB first
// PARITY | resolving the parity bit (UART_RX_PARITY_EN only)
// STOP   | resolving the stop bit; push/flag, back to IDLE at mid-bit
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_PER_BAUD = 2604,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          RX,
  input  logic                          rd_en,
  input  logic                          clr_err,
`ifdef UART_RX_PARITY_EN
  input  logic                          parity_odd,
  output logic                          parity_err,
`endif
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_rdy,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int M     = CLK_PER_BAUD / 2;
  localparam int CNT_W = $clog2(CLK_PER_BAUD);
  localparam int BIT_W = 4;

  localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(M - 1);
  localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(M);
  localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(M + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_PER_BAUD - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rx_s1_q, rx_s1_d;
  logic                 rx_s2_q, rx_s2_d;
  logic                 rx_e_q, rx_e_d;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
  logic                 par_set;
`endif

  logic                 start_edge, resolve, bit_val;
  logic                 frame_set, ovr_set;
  logic                 fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign start_edge = ~rx_s2_q & rx_e_q;
  assign resolve    = (baud_cnt_q == SAMP_C);
  assign bit_val    = maj3(samp_q[1], samp_q[0], rx_s2_q);
  assign fifo_pop   = rd_en & ~fifo_empty;

  // Synchroniser and edge-detect stage inputs.
  always_comb begin
    rx_s1_d = RX;
    rx_s2_d = rx_s1_q;
    rx_e_d  = rx_s2_q;
  end

  // Frame sequencing, bit sampling and push/flag decisions.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    fifo_push  = 1'b0;
    frame_set  = 1'b0;
    ovr_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    par_set    = 1'b0;
`endif

    if (state_q != IDLE) begin
      baud_cnt_d = (baud_cnt_q == CNT_MAX) ? '0 : baud_cnt_q + CNT_W'(1);
      if (baud_cnt_q == SAMP_A) samp_d[1] = rx_s2_q;
      if (baud_cnt_q == SAMP_B) samp_d[0] = rx_s2_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d    = START;
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (resolve) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (resolve) begin
          shift_d   = {bit_val, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (resolve) begin
          par_bad_d = ((^shift_q) ^ bit_val) != parity_odd;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        // Leave at mid-bit so a back-to-back start edge is caught in IDLE.
        if (resolve) begin
          state_d = IDLE;
          if (!bit_val) begin
            frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            par_set = 1'b1;
`endif
          end else if (fifo_full && !fifo_pop) begin
            ovr_set = 1'b1;
          end else begin
            fifo_push = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    frame_err_d  = frame_set | (frame_err_q & ~clr_err);
    overrun_d    = ovr_set   | (overrun_q   & ~clr_err);
`ifdef UART_RX_PARITY_EN
    parity_err_d = par_set   | (parity_err_q & ~clr_err);
`endif
  end

  // Synchroniser flops preset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_e_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx_s1_d;
      rx_s2_q <= rx_s2_d;
      rx_e_q  <= rx_e_d;
    end
  end

  // Receiver state, counters, shift register and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      samp_q       <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      samp_q       <= samp_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (shift_q),
    .dout (rx_data),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  assign rx_rdy    = ~fifo_empty;
  assign rx_count  = fifo_count;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: drives serial frames cycle by cycle and compares
// the DUT against a queue-based model of the receive FIFO and error flags.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;
  localparam int M     = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = DB + 3;
`else
  localparam int NBITS = DB + 2;
`endif
  // Driver index at which the stop-bit decision becomes visible: stop bit
  // resolves at cycle (NBITS-1)*CPB+M+1 after START entry, and START is
  // entered 2 clocks after the first low sample, the result 1 clock later.
  localparam int UPD = (NBITS - 1) * CPB + M + 1 + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd;
  logic       parity_err;
`endif

  logic [7:0] mq[$];
  logic       m_frame, m_ovr, m_par;
  bit         chk_en;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_PER_BAUD(CPB),
    .DATA_BITS   (DB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
`ifdef UART_RX_PARITY_EN
    .parity_odd(parity_odd),
    .parity_err(parity_err),
`endif
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("rx_count", {29'd0, rx_count}, mq.size());
      check("rx_rdy", {31'd0, rx_rdy}, {31'd0, (mq.size() > 0)});
      if (mq.size() > 0) check("rx_data", {24'd0, rx_data}, {24'd0, mq[0]});
      check("frame_err", {31'd0, frame_err}, {31'd0, m_frame});
      check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
`ifdef UART_RX_PARITY_EN
      check("parity_err", {31'd0, parity_err}, {31'd0, m_par});
`endif
    end
  end

  task automatic apply_outcome(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    logic par_bad;
    par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad = ((^data) ^ par_bit) != parity_odd;
`else
    par_bad = par_bit & 1'b0;
`endif
    if (!stop_bit) m_frame = 1'b1;
    else if (par_bad) m_par = 1'b1;
    else if (mq.size() == DEPTH) m_ovr = 1'b1;
    else mq.push_back(data);
  endtask

  // One frame, one driver step per clock; optional glitch, pop or reset index.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit,
                            input int glitch_j, input int pop_j, input int abort_j);
    logic bits [NBITS];
    bits[0] = 1'b0;
    for (int i = 0; i < DB; i++) bits[i+1] = data[i];
`ifdef UART_RX_PARITY_EN
    bits[DB+1] = par_bit;
`endif
    bits[NBITS-1] = stop_bit;
    for (int j = 0; j < NBITS * CPB; j++) begin
      @(negedge clk);
      if (j == abort_j) begin
        rst_n = 1'b0;
        RX    = 1'b1;
        rd_en = 1'b0;
        mq.delete();
        m_frame = 1'b0;
        m_ovr   = 1'b0;
        m_par   = 1'b0;
        return;
      end
      RX    = bits[j/CPB] ^ (j == glitch_j);
      rd_en = (j == pop_j);
      if (j == pop_j && mq.size() > 0) void'(mq.pop_front());
      if (j == UPD) apply_outcome(data, stop_bit, par_bit);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      RX      = 1'b1;
      rd_en   = 1'b0;
      clr_err = 1'b0;
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    rd_en = 1'b1;
    if (mq.size() > 0) void'(mq.pop_front());
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    clr_err = 1'b1;
    m_frame = 1'b0;
    m_ovr   = 1'b0;
    m_par   = 1'b0;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic send(input logic [7:0] data);
    send_frame(data, 1'b1, ^data, -1, -1, -1);
  endtask

  initial begin
    rst_n   = 1'b0;
    RX      = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    m_frame = 1'b0;
    m_ovr   = 1'b0;
    m_par   = 1'b0;
    chk_en  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("reset_count", {29'd0, rx_count}, 32'd0);
    check("reset_rdy", {31'd0, rx_rdy}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_flags", {29'd0, frame_err, overrun, 1'b0}, 32'd0);
    chk_en = 1'b1;

    // Back-to-back 0xA5, 0x3C
    send(8'hA5);
    send(8'h3C);
    idle(20);
    check("b2b_count", {29'd0, rx_count}, 32'd2);
    check("b2b_head_a5", {24'd0, rx_data}, 32'hA5);
    pop_one();
    check("b2b_head_3c", {24'd0, rx_data}, 32'h3C);
    pop_one();
    check("b2b_empty", {31'd0, rx_rdy}, 32'd0);

    // 5-clock low pulse: false start, then a normal frame must still land
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      RX = 1'b0;
    end
    idle(40);
    check("false_start_count", {29'd0, rx_count}, 32'd0);
    send(8'h81);
    idle(20);
    check("after_false_start", {24'd0, rx_data}, 32'h81);
    pop_one();

    // Single-clock glitch on the middle sample of data bit 3
    send_frame(8'h00, 1'b1, 1'b0, 4 * CPB + M + 1, -1, -1);
    idle(20);
    check("glitch_count", {29'd0, rx_count}, 32'd1);
    check("glitch_data", {24'd0, rx_data}, 32'h00);
    pop_one();

    // Stop bit low
    send_frame(8'h55, 1'b0, 1'b0, -1, -1, -1);
    idle(20);
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_count", {29'd0, rx_count}, 32'd0);
    clear_err();
    check("ferr_cleared", {31'd0, frame_err}, 32'd0);

    // Five frames into a 4-deep FIFO
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    idle(20);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_count", {29'd0, rx_count}, 32'd4);
    check("ovr_head", {24'd0, rx_data}, 32'h11);
    repeat (4) pop_one();
    clear_err();

    // Same, with a pop on the fifth push cycle
    send(8'h61);
    send(8'h62);
    send(8'h63);
    send(8'h64);
    send_frame(8'h65, 1'b1, ^8'h65, -1, UPD, -1);
    idle(20);
    check("pop_push_no_ovr", {31'd0, overrun}, 32'd0);
    check("pop_push_count", {29'd0, rx_count}, 32'd4);
    check("pop_push_head", {24'd0, rx_data}, 32'h62);
    repeat (4) pop_one();

`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, -1, -1, -1);
    idle(20);
    check("par_err_set", {31'd0, parity_err}, 32'd1);
    check("par_err_count", {29'd0, rx_count}, 32'd0);
    clear_err();
    send_frame(8'h07, 1'b1, 1'b1, -1, -1, -1);
    idle(20);
    check("par_ok_data", {24'd0, rx_data}, 32'h07);
    pop_one();
`endif

    // Reset mid-frame with data buffered and a flag set
    send(8'h9A);
    send_frame(8'h55, 1'b0, 1'b0, -1, -1, -1);
    idle(5);
    send_frame(8'h66, 1'b1, 1'b0, -1, -1, 80);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check("abort_count", {29'd0, rx_count}, 32'd0);
    check("abort_ferr", {31'd0, frame_err}, 32'd0);
    send(8'hC3);
    idle(20);
    check("after_abort_data", {24'd0, rx_data}, 32'hC3);
    pop_one();
    idle(5);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
